// File: rtl/tick_debouncer_pkg.sv
// Shared FSM encoding and counter widths for the tick-sampled button debouncer.
// Imported by tick_edge_sync and tick_debouncer.
package tick_debouncer_pkg;

  localparam int CNT_W  = 8;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_e;

endpackage

// File: rtl/tick_edge_sync.sv
// Two-flop synchronizer; with EDGE=1 adds a history flop and a registered rising-edge strobe.
// Latency: q is the synced level 2 cycles late (EDGE=0), or the strobe in the 3rd cycle after t is first sampled high (EDGE=1).
module tick_edge_sync
  import tick_debouncer_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic hist, rise;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hist <= 1'b0;
          rise <= 1'b0;
        end else begin
          hist <= s2;
          rise <= s2 & ~hist;
        end
      end

      assign q = rise;
    end else begin : g_level
      assign q = s2;
    end
  endgenerate

endmodule

// File: rtl/tick_debouncer.sv
// Debounces btn_raw by sampling it on rising edges of the slow time base t; level and press/release pulses change 1 cycle after the qualifying tick.
// Optional long-press pulse on btn_long when TICK_DEBOUNCER_LONG_PRESS_EN is defined.
module tick_debouncer
  import tick_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int HOLD_TICKS   = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  input  logic btn_raw,
  output logic tick,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
  ,
  output logic btn_long
`endif
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_TICKS);

  logic btn_s;

  tick_edge_sync #(.EDGE(1'b1)) u_t_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (t),
    .q     (tick)
  );

  tick_edge_sync #(.EDGE(1'b0)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // IDLE and PRESSED always hold cnt=0, so they share the pending-state arithmetic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE, PRESS_PEND: begin
          if (btn_s) begin
            state_d = PRESS_PEND;
            cnt_d   = cnt_inc;
            if (cnt_inc == STABLE) begin
              state_d = PRESSED;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED, RELEASE_PEND: begin
          if (!btn_s) begin
            state_d = RELEASE_PEND;
            cnt_d   = cnt_inc;
            if (cnt_inc == STABLE) begin
              state_d   = IDLE;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(HOLD_TICKS);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Count freezes in RELEASE_PEND and saturates at HOLD so the pulse fires once per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (tick && state_q == PRESSED && hold_q != HOLD) begin
      hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
      long_d = (hold_d == HOLD);
    end
    if (state_d == IDLE) begin
      hold_d = '0;
    end
  end

  assign btn_long = long_q;
`endif

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench: cycle-accurate behavioural model plus directed event-count checks and random button stimulus.
module tb_tick_debouncer;

  localparam int STABLE = 4;
  localparam int HOLD   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic t;
  logic btn_raw;
  logic d_tick, d_level, d_press, d_release;
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
  logic d_long;
`endif

  tick_debouncer #(.STABLE_TICKS(STABLE), .HOLD_TICKS(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .t           (t),
    .btn_raw     (btn_raw),
    .tick        (d_tick),
    .btn_level   (d_level),
    .btn_press   (d_press),
    .btn_release (d_release)
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
    ,
    .btn_long    (d_long)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t/btn sample history, debounced level, run of differing samples, ticks held pressed.
  typedef struct packed {
    logic [3:0] th;
    logic [1:0] bh;
    bit         level;
    int         run;
    int         hold;
    bit         tick;
    bit         press;
    bit         rel;
    bit         lng;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t cur, input logic tv, input logic bv);
    mdl_t nx;
    logic samp;
    nx       = cur;
    samp     = cur.bh[1];
    nx.tick  = cur.th[1] & ~cur.th[2];
    nx.press = 1'b0;
    nx.rel   = 1'b0;
    nx.lng   = 1'b0;
    if (cur.tick) begin
      if (cur.level && cur.run == 0 && cur.hold < HOLD) begin
        nx.hold = cur.hold + 1;
        nx.lng  = (nx.hold == HOLD);
      end
      if (samp != cur.level) begin
        nx.run = cur.run + 1;
        if (nx.run == STABLE) begin
          nx.level = ~cur.level;
          nx.run   = 0;
          if (nx.level) nx.press = 1'b1;
          else begin
            nx.rel  = 1'b1;
            nx.hold = 0;
          end
        end
      end else begin
        nx.run = 0;
      end
    end
    nx.th = {cur.th[2:0], tv};
    nx.bh = {cur.bh[0], bv};
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, t, btn_raw);
  end

  bit chk_en = 1'b0;
  int ev_tick = 0, ev_press = 0, ev_rel = 0, ev_long = 0;
  int tick_at_press = 0, tick_at_rel = 0, tick_at_long = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tick", d_tick, m.tick);
      chk("level", d_level, m.level);
      chk("press", d_press, m.press);
      chk("release", d_release, m.rel);
      chk("press_release_excl", d_press & d_release, 0);
`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
      chk("long", d_long, m.lng);
      if (d_long === 1'b1) begin ev_long++; tick_at_long = ev_tick; end
`endif
      if (d_tick === 1'b1) ev_tick++;
      if (d_press === 1'b1) begin ev_press++; tick_at_press = ev_tick; end
      if (d_release === 1'b1) begin ev_rel++; tick_at_rel = ev_tick; end
    end
  end

  bit t_run = 1'b0;
  int t_half = 4;
  int t_ph = 0;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
    if (t_run) begin
      t_ph++;
      if (t_ph >= t_half) begin
        t_ph = 0;
        t = ~t;
      end
    end
  endtask

  function automatic int ev_of(input int which);
    case (which)
      0:       return ev_tick;
      1:       return ev_press;
      2:       return ev_rel;
      default: return ev_long;
    endcase
  endfunction

  task automatic wait_ev(input string nm, input int which, input int target, input int budget);
    int k = 0;
    while (ev_of(which) < target && k < budget) begin
      cyc();
      k++;
    end
    if (ev_of(which) < target) chk({nm, "_timeout"}, ev_of(which), target);
  endtask

  task automatic settle_btn(input logic v);
    t_run   = 1'b0;
    btn_raw = v;
    repeat (5) cyc();
  endtask

  task automatic resume_t();
    t_ph  = 0;
    t_run = 1'b1;
  endtask

  int base_t, base_p, base_r, base_l;

  initial begin
    rst_n   = 1'b0;
    t       = 1'b0;
    btn_raw = 1'b0;
    t_run   = 1'b1;

    // Reset held with t toggling: every output stays 0.
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("rst_tick", d_tick, 0);
      chk("rst_level", d_level, 0);
      chk("rst_pulses", {d_press, d_release}, 0);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // One tick per 8-cycle period of t.
    repeat (10) cyc();
    base_t = ev_tick;
    repeat (40) cyc();
    chk("tick_rate", ev_tick - base_t, 5);

    // Tick appears in the 3rd cycle after t is first sampled high.
    t_run = 1'b0;
    t     = 1'b0;
    repeat (6) cyc();
    t = 1'b1;
    cyc(); chk("tick_lat_c1", d_tick, 0);
    cyc(); chk("tick_lat_c2", d_tick, 0);
    cyc(); chk("tick_lat_c3", d_tick, 1);
    cyc(); chk("tick_lat_c4", d_tick, 0);

    // Frozen time base: button held but nothing moves.
    btn_raw = 1'b1;
    base_t = ev_tick; base_p = ev_press;
    repeat (1000) cyc();
    chk("frozen_ticks", ev_tick - base_t, 0);
    chk("frozen_press", ev_press - base_p, 0);
    chk("frozen_level", d_level, 0);

    // Resume: press after exactly STABLE ticks.
    base_t = ev_tick;
    resume_t();
    wait_ev("press1", 1, base_p + 1, 200);
    chk("press1_ticks", tick_at_press - base_t, STABLE);
    cyc();
    chk("press1_level", d_level, 1);

    // Release after STABLE ticks of btn low.
    settle_btn(1'b0);
    base_t = ev_tick; base_r = ev_rel; base_p = ev_press;
    resume_t();
    wait_ev("rel1", 2, base_r + 1, 200);
    chk("rel1_ticks", tick_at_rel - base_t, STABLE);
    cyc();
    chk("rel1_level", d_level, 0);
    chk("rel1_no_press", ev_press - base_p, 0);

    // Short 2-tick bounce: no pulse, back to idle.
    settle_btn(1'b1);
    base_t = ev_tick; base_p = ev_press;
    resume_t();
    wait_ev("glitch_ticks", 0, base_t + 2, 100);
    t_run = 1'b0;
    t     = 1'b0;
    settle_btn(1'b0);
    resume_t();
    repeat (80) cyc();
    chk("glitch_no_press", ev_press - base_p, 0);
    chk("glitch_level", d_level, 0);
    settle_btn(1'b1);
    base_t = ev_tick;
    resume_t();
    wait_ev("press2", 1, base_p + 1, 200);
    chk("press2_ticks", tick_at_press - base_t, STABLE);
    cyc();

    // Reset while pressed drops the level at once.
    t_run = 1'b0;
    chk("pre_rst_level", d_level, 1);
    #1 rst_n = 1'b0;
    #1 chk("rst_pressed_level", d_level, 0);
    btn_raw = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Reset with a pending press (cnt=3): nothing emerges afterwards.
    settle_btn(1'b1);
    base_t = ev_tick; base_p = ev_press;
    resume_t();
    wait_ev("pend_ticks", 0, base_t + 3, 100);
    t_run = 1'b0;
    cyc();
    chk("pend_level", d_level, 0);
    #1 rst_n = 1'b0;
    #1 chk("rst_pend_outputs", {d_tick, d_level, d_press, d_release}, 0);
    btn_raw = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    resume_t();
    repeat (80) cyc();
    chk("rst_pend_no_press", ev_press - base_p, 0);
    chk("rst_pend_level", d_level, 0);

`ifdef TICK_DEBOUNCER_LONG_PRESS_EN
    // Long press: one pulse HOLD ticks after entering PRESSED, restarted by a fresh press.
    for (int r = 0; r < 2; r++) begin
      settle_btn(1'b1);
      base_p = ev_press; base_l = ev_long;
      resume_t();
      wait_ev("long_press", 1, base_p + 1, 200);
      base_t = tick_at_press;
      wait_ev("long_hold", 0, base_t + 10, 200);
      repeat (2) cyc();
      chk("long_count", ev_long - base_l, 1);
      chk("long_ticks", tick_at_long - base_t, HOLD);
      settle_btn(1'b0);
      base_r = ev_rel;
      resume_t();
      wait_ev("long_rel", 2, base_r + 1, 200);
    end
`endif

    // Random bouncing button with occasional time-base stalls.
    resume_t();
    for (int s = 0; s < 300; s++) begin
      btn_raw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) t_run = ~t_run;
      repeat ($urandom_range(1, 80)) cyc();
    end
    t_run = 1'b1;
    repeat (20) cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
